// File: rtl/rate_divider_bank.sv
// Bank of independent programmable clock dividers. Period/high-time writes land in a
// shadow and take effect only at a period wrap or while the channel is stopped.
module rate_divider_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CW    = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [NCH-1:0]   enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [WIDTH-1:0] L_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] L_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Last counter value of a period; a halted (P=0) channel parks at zero.
  function automatic logic [WIDTH-1:0] f_last_count(input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] v;
    if (p == L_ZERO) begin
      v = L_ZERO;
    end else begin
      v = p - L_ONE;
    end
    return v;
  endfunction

  logic [NCH-1:0] w_hit;
  logic [NCH-1:0] w_pend;
  logic           w_accept;

  // Decode the write target; out-of-range channel numbers hit nothing.
  always_comb begin
    w_hit = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      w_hit[i] = (cfg_ch == CW'(i));
    end
  end

  assign cfg_ready = ~reset & |(w_hit & ~w_pend);
  assign w_accept  = cfg_valid & cfg_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] r_p, r_h, r_c, r_sp, r_sh;
    logic             r_pend, r_clk, r_tick;
    logic [WIDTH-1:0] w_ep, w_eh, w_cn;
    logic             w_run, w_last, w_apply, w_wr;

    // Per-channel next count and effective configuration for this edge.
    always_comb begin
      w_run   = enable[g] & (r_p != L_ZERO);
      w_last  = w_run & (r_c == f_last_count(r_p));
      w_apply = r_pend & (~enable[g] | (r_p == L_ZERO) | w_last);
      w_wr    = w_accept & w_hit[g];
      w_ep    = w_apply ? r_sp : r_p;
      w_eh    = w_apply ? r_sh : r_h;
      w_cn    = w_last ? L_ZERO : (r_c + L_ONE);
    end

    // Counter, outputs, and shadow/pending bookkeeping.
    always_ff @(posedge clk_in) begin
      if (reset) begin
        r_p    <= L_ZERO;
        r_h    <= L_ZERO;
        r_c    <= L_ZERO;
        r_sp   <= L_ZERO;
        r_sh   <= L_ZERO;
        r_pend <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        if (w_apply) begin
          r_p <= r_sp;
          r_h <= r_sh;
        end
        if (w_wr) begin
          r_sp   <= cfg_period;
          r_sh   <= cfg_high;
          r_pend <= 1'b1;
        end else if (w_apply) begin
          r_pend <= 1'b0;
        end
        // A stopped channel parks on its last count so the first enabled edge wraps.
        if (!w_run) begin
          r_c    <= f_last_count(w_ep);
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_ep == L_ZERO) begin
          r_c    <= L_ZERO;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else begin
          r_c    <= w_cn;
          r_clk  <= (w_cn < w_eh);
          r_tick <= (w_cn == L_ZERO);
        end
      end
    end

    assign w_pend[g]  = r_pend;
    assign clk_out[g] = r_clk;
    assign tick[g]    = r_tick;
  end

endmodule

// File: tb/tb_rate_divider_bank.sv
// Self-checking bench for rate_divider_bank: directed vector table, corner-case
// sequences, and randomized traffic against a period-position reference model.
module tb_rate_divider_bank;
  localparam int NCH = 4;
  localparam int WIDTH = 32;
  localparam int CW = 2;

  logic             clk_in = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   enable = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CW-1:0]    cfg_ch = '0;
  logic [WIDTH-1:0] cfg_period = '0;
  logic [WIDTH-1:0] cfg_high = '0;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  rate_divider_bank #(.NCH(NCH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_high(cfg_high), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  logic last_ready;

  // Reference model: each channel's position inside its period (-1 = armed, next run edge starts a period).
  int m_p[NCH], m_h[NCH], m_sp[NCH], m_sh[NCH], m_pos[NCH];
  bit m_pend[NCH];
  logic [NCH-1:0] e_clk = '0, e_tick = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    return !reset && !m_pend[cfg_ch];
  endfunction

  task automatic model_edge();
    bit acc;
    bit bnd;
    int op;
    acc = cfg_valid && model_ready();
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_p[c] = 0; m_h[c] = 0; m_sp[c] = 0; m_sh[c] = 0; m_pos[c] = -1; m_pend[c] = 0;
      end
      e_clk = '0;
      e_tick = '0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      op  = m_p[c];
      bnd = !enable[c] || op == 0 || m_pos[c] == -1 || m_pos[c] == op - 1;
      if (m_pend[c] && bnd) begin
        m_p[c] = m_sp[c]; m_h[c] = m_sh[c]; m_pend[c] = 0;
      end
      if (!enable[c] || op == 0) begin
        m_pos[c] = -1; e_clk[c] = 1'b0; e_tick[c] = 1'b0;
      end else begin
        m_pos[c] = (m_pos[c] == -1 || m_pos[c] == op - 1) ? 0 : m_pos[c] + 1;
        if (m_p[c] == 0) begin
          m_pos[c] = -1; e_clk[c] = 1'b0; e_tick[c] = 1'b0;
        end else begin
          e_tick[c] = (m_pos[c] == 0);
          e_clk[c]  = (m_pos[c] < m_h[c]);
        end
      end
    end
    if (acc) begin
      m_sp[cfg_ch] = int'(cfg_period); m_sh[cfg_ch] = int'(cfg_high); m_pend[cfg_ch] = 1;
    end
  endtask

  // One clock: drive at the falling edge, check ready, advance model, check outputs at next falling edge.
  task automatic cycle(input bit rst, input logic [NCH-1:0] en, input bit v,
                       input int ch, input int p, input int h);
    reset = rst; enable = en; cfg_valid = v;
    cfg_ch = CW'(ch); cfg_period = WIDTH'(p); cfg_high = WIDTH'(h);
    #1;
    last_ready = cfg_ready;
    check("cfg_ready", {31'd0, cfg_ready}, {31'd0, model_ready()});
    model_edge();
    @(posedge clk_in);
    @(negedge clk_in);
    check("clk_out", {28'd0, clk_out}, {28'd0, e_clk});
    check("tick", {28'd0, tick}, {28'd0, e_tick});
  endtask

  typedef struct {
    bit rst; logic [3:0] en; bit v; int ch; int p; int h;
    bit exp_ready; logic [3:0] exp_clk; logic [3:0] exp_tick;
  } vec_t;
  vec_t tbl[12];

  int n_tick, n_high;
  logic [3:0] ren;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_p[c] = 0; m_h[c] = 0; m_sp[c] = 0; m_sh[c] = 0; m_pos[c] = -1; m_pend[c] = 0;
    end
    // Reset, configure ch0 P=4 H=2, run: tick + 1100 repeating.
    tbl[0]  = '{1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0};
    tbl[1]  = '{0, 4'h0, 1, 0, 4, 2, 1, 4'h0, 4'h0};
    tbl[2]  = '{0, 4'h1, 0, 0, 0, 0, 0, 4'h0, 4'h0};
    tbl[3]  = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h1, 4'h1};
    tbl[4]  = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h1, 4'h0};
    tbl[5]  = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[6]  = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[7]  = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h1, 4'h1};
    tbl[8]  = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h1, 4'h0};
    tbl[9]  = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[10] = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h0, 4'h0};
    tbl[11] = '{0, 4'h1, 0, 0, 0, 0, 1, 4'h1, 4'h1};

    @(negedge clk_in);
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].ch, tbl[i].p, tbl[i].h);
      check($sformatf("vec%0d_ready", i), {31'd0, last_ready}, {31'd0, tbl[i].exp_ready});
      check($sformatf("vec%0d_clk", i), {28'd0, clk_out}, {28'd0, tbl[i].exp_clk});
      check($sformatf("vec%0d_tick", i), {28'd0, tick}, {28'd0, tbl[i].exp_tick});
    end

    // Mid-period retune of ch0 to P=3 H=1; second write while pending is refused.
    cycle(0, 4'h1, 1, 0, 3, 1);
    cfg_valid = 1'b0; cfg_ch = 2'd0; #1;
    check("pend_ready_ch0", {31'd0, cfg_ready}, 32'd0);
    cfg_ch = 2'd1; #1;
    check("pend_ready_ch1", {31'd0, cfg_ready}, 32'd1);
    cycle(0, 4'h1, 1, 0, 6, 6);
    check("second_write_ready", {31'd0, last_ready}, 32'd0);
    cycle(0, 4'h1, 0, 0, 0, 0);
    check("old_period_clk", {31'd0, clk_out[0]}, 32'd0);
    cycle(0, 4'h1, 0, 0, 0, 0);
    check("wrap_apply_clk", {31'd0, clk_out[0]}, 32'd1);
    check("wrap_apply_tick", {31'd0, tick[0]}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 4'h1, 0, 0, 0, 0);
      check($sformatf("p3_clk_%0d", k), {31'd0, clk_out[0]}, (k % 3 == 2) ? 32'd1 : 32'd0);
      check($sformatf("p3_tick_%0d", k), {31'd0, tick[0]}, (k % 3 == 2) ? 32'd1 : 32'd0);
    end

    // ch1 P=5 with H=0 then H=7: constant low, then constant high, ticks every 5.
    cycle(0, 4'h3, 1, 1, 5, 0);
    cycle(0, 4'h3, 0, 0, 0, 0);
    n_tick = 0; n_high = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 4'h3, 0, 0, 0, 0);
      n_tick += int'(tick[1]); n_high += int'(clk_out[1]);
    end
    check("h0_ticks", n_tick, 2);
    check("h0_high", n_high, 0);
    cycle(0, 4'h3, 1, 1, 5, 7);
    for (int k = 0; k < 5; k++) cycle(0, 4'h3, 0, 0, 0, 0);
    n_tick = 0; n_high = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 4'h3, 0, 0, 0, 0);
      n_tick += int'(tick[1]); n_high += int'(clk_out[1]);
    end
    check("h7_ticks", n_tick, 2);
    check("h7_high", n_high, 10);

    // ch2 P=3 H=2; drop its enable for three cycles, then raise it.
    cycle(0, 4'h7, 1, 2, 3, 2);
    for (int k = 0; k < 6; k++) cycle(0, 4'h7, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 4'h3, 0, 0, 0, 0);
      check($sformatf("en_low_clk_%0d", k), {31'd0, clk_out[2]}, 32'd0);
      check($sformatf("en_low_tick_%0d", k), {31'd0, tick[2]}, 32'd0);
    end
    cycle(0, 4'h7, 0, 0, 0, 0);
    check("en_rise_tick", {31'd0, tick[2]}, 32'd1);
    check("en_rise_clk", {31'd0, clk_out[2]}, 32'd1);

    // Reset with a ch0 update pending; nothing may be applied afterwards.
    cycle(0, 4'h7, 1, 0, 5, 3);
    cycle(1, 4'hF, 1, 1, 2, 1);
    check("rst_clk", {28'd0, clk_out}, 32'd0);
    check("rst_tick", {28'd0, tick}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 4'hF, 0, 0, 0, 0);
      check($sformatf("post_rst_ready_%0d", k), {31'd0, last_ready}, 32'd1);
      check($sformatf("post_rst_out_%0d", k), {24'd0, clk_out, tick}, 32'd0);
    end

    // Randomized traffic against the model.
    ren = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) ren = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 299) == 0, ren, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
